// File: rtl/mux_8by1_rr_arbiter.sv
// mux_8by1_rr_arbiter: round-robin grant sequencer driving the select of an 8:1 single-bit mux
module mux_8by1_rr_arbiter #(
    parameter int NUM_REQ  = 8,
    parameter int SEL_W    = $clog2(NUM_REQ),
    parameter int MAX_HOLD = 4,
    parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] i_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [SEL_W-1:0]   sel_o,
    output logic               valid_o,
    output logic               y_o
);
    typedef enum logic {IDLE, GRANT} state_t;
    state_t             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d, sel_q, sel_d, base, win;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               valid_q, valid_d, found, rel;
    // Priority search: on a release it starts just past the current grant, otherwise at ptr.
    always_comb begin
        base  = (state_q == GRANT) ? sel_q + 1'b1 : ptr_q;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_i[base + SEL_W'(k)]) begin
                found = 1'b1;
                win   = base + SEL_W'(k);
            end
        end
    end
    // Next state: grant from idle, hold while the grant lasts, re-arbitrate on release with no bubble.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        rel     = !req_i[sel_q] || (cnt_q == CNT_W'(MAX_HOLD));
        if (state_q == GRANT && !rel) begin
            cnt_d = cnt_q + 1'b1;
        end else if (state_q == GRANT || found) begin
            if (state_q == GRANT) ptr_d = base;
            if (found) begin
                state_d = GRANT;
                sel_d   = win;
                gnt_d   = NUM_REQ'(1) << win;
                valid_d = 1'b1;
                cnt_d   = CNT_W'(1);
            end else begin
                state_d = IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
                cnt_d   = '0;
            end
        end
    end
    // State registers; reset clears every output at once without waiting for a clock.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
        end
    end
    assign gnt_o   = gnt_q;
    assign sel_o   = sel_q;
    assign valid_o = valid_q;
    assign y_o     = valid_q & i_i[sel_q];
endmodule

// File: tb/tb_mux_8by1_rr_arbiter.sv
// tb_mux_8by1_rr_arbiter: directed vector bench for the round-robin mux arbiter
module tb_mux_8by1_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req, din, gnt;
    logic [2:0] sel;
    logic       valid, y;
    int         n_chk = 0;
    int         n_fail = 0;

    typedef struct {
        logic [7:0] req;
        logic [7:0] din;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       valid;
        logic       y;
    } vec_t;
    vec_t tbl [18];

    mux_8by1_rr_arbiter dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .i_i(din),
        .gnt_o(gnt), .sel_o(sel), .valid_o(valid), .y_o(y)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] ip;
        tbl[0]  = '{8'h40, 8'hA5, 8'h40, 3'd6, 1'b1, 1'b0};
        tbl[1]  = '{8'h21, 8'hA5, 8'h01, 3'd0, 1'b1, 1'b1};
        tbl[2]  = '{8'h21, 8'hA5, 8'h01, 3'd0, 1'b1, 1'b1};
        tbl[3]  = '{8'h20, 8'hA5, 8'h20, 3'd5, 1'b1, 1'b1};
        tbl[4]  = '{8'h20, 8'h5A, 8'h20, 3'd5, 1'b1, 1'b0};
        tbl[5]  = '{8'h00, 8'hA5, 8'h00, 3'd5, 1'b0, 1'b0};
        tbl[6]  = '{8'h80, 8'hA5, 8'h80, 3'd7, 1'b1, 1'b1};
        tbl[7]  = '{8'h82, 8'hA5, 8'h80, 3'd7, 1'b1, 1'b1};
        tbl[8]  = '{8'h82, 8'hA5, 8'h80, 3'd7, 1'b1, 1'b1};
        tbl[9]  = '{8'h82, 8'hA5, 8'h80, 3'd7, 1'b1, 1'b1};
        tbl[10] = '{8'h82, 8'hA5, 8'h02, 3'd1, 1'b1, 1'b0};
        tbl[11] = '{8'h00, 8'hA5, 8'h00, 3'd1, 1'b0, 1'b0};
        tbl[12] = '{8'h08, 8'hA5, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[13] = '{8'h08, 8'hA5, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[14] = '{8'h08, 8'hA5, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[15] = '{8'h08, 8'hA5, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[16] = '{8'h30, 8'hA5, 8'h10, 3'd4, 1'b1, 1'b0};
        tbl[17] = '{8'h00, 8'hA5, 8'h00, 3'd4, 1'b0, 1'b0};

        rst = 1'b1; req = 8'hFF; din = 8'hFF;
        #1;
        check("t1_gnt", gnt, 8'h00);
        check("t1_sel", {5'd0, sel}, 8'd0);
        check("t1_valid", {7'd0, valid}, 8'd0);
        check("t1_y", {7'd0, y}, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        req = 8'h04; din = 8'h04;
        @(negedge clk);
        check("t2_gnt", gnt, 8'h04);
        check("t2_sel", {5'd0, sel}, 8'd2);
        check("t2_valid", {7'd0, valid}, 8'd1);
        check("t2_y", {7'd0, y}, 8'd1);
        din = 8'h00;
        #1;
        check("t2_y_comb", {7'd0, y}, 8'd0);
        req = 8'h00;
        @(negedge clk);
        check("t2_gnt_off", gnt, 8'h00);
        check("t2_valid_off", {7'd0, valid}, 8'd0);
        check("t2_sel_hold", {5'd0, sel}, 8'd2);

        for (int v = 0; v < 18; v++) begin
            req = tbl[v].req; din = tbl[v].din;
            @(negedge clk);
            check($sformatf("vec%0d_gnt", v), gnt, tbl[v].gnt);
            check($sformatf("vec%0d_sel", v), {5'd0, sel}, {5'd0, tbl[v].sel});
            check($sformatf("vec%0d_valid", v), {7'd0, valid}, {7'd0, tbl[v].valid});
            check($sformatf("vec%0d_y", v), {7'd0, y}, {7'd0, tbl[v].y});
        end

        pulse_reset();
        ip = 8'h5A; req = 8'hFF; din = ip;
        for (int n = 0; n < 36; n++) begin
            @(negedge clk);
            check($sformatf("t3_sel_c%0d", n), {5'd0, sel}, 8'((n / 4) % 8));
            check($sformatf("t3_valid_c%0d", n), {7'd0, valid}, 8'd1);
            check($sformatf("t3_cnt_c%0d", n), 8'(dut.cnt_q), 8'(n % 4 + 1));
            check($sformatf("t3_y_c%0d", n), {7'd0, y}, {7'd0, ip[(n / 4) % 8]});
        end

        pulse_reset();
        req = 8'h08;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check($sformatf("t5_gnt_c%0d", n), gnt, 8'h08);
            check($sformatf("t5_valid_c%0d", n), {7'd0, valid}, 8'd1);
            check($sformatf("t5_cnt_c%0d", n), 8'(dut.cnt_q), 8'(n % 4 + 1));
        end

        pulse_reset();
        req = 8'hFF;
        for (int n = 0; n < 21; n++) begin
            @(negedge clk);
            check($sformatf("t6_sel_c%0d", n), {5'd0, sel}, 8'(n / 4));
        end
        #1 rst = 1'b1;
        #1;
        check("t6_gnt_rst", gnt, 8'h00);
        check("t6_sel_rst", {5'd0, sel}, 8'd0);
        check("t6_valid_rst", {7'd0, valid}, 8'd0);
        check("t6_y_rst", {7'd0, y}, 8'd0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t6_gnt_after", gnt, 8'h01);
        check("t6_sel_after", {5'd0, sel}, 8'd0);
        check("t6_valid_after", {7'd0, valid}, 8'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
